// File: rtl/alu_pipe.sv
// ============================================================================
// Module   : alu_pipe
// Brief    : Registered ALU with valid/ready handshakes, Z/C/N/V flags and a
//            multi-cycle shift-add multiplier.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_pipe #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             flag_zero,
    output logic             flag_carry,
    output logic             flag_neg,
    output logic             flag_ovf,
    output logic             err
);

    localparam int         CW     = $clog2(WIDTH);
    localparam int         M      = WIDTH - 1;
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MUL  = 1'b1;

    localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_INC = 4'h2, OP_DEC = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4, OP_OR  = 4'h5, OP_XOR = 4'h6, OP_NOT = 4'h7;
    localparam logic [3:0] OP_SHL = 4'h8, OP_SHR = 4'h9, OP_ASR = 4'hA, OP_ADC = 4'hB;
    localparam logic [3:0] OP_MUL = 4'hC;

    logic [0:0]         r_state;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_prod;
    logic [CW-1:0]      r_cnt;

    logic [WIDTH-1:0]   w_addb;
    logic               w_addc;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [SHW-1:0]     w_sh;
    logic [WIDTH:0]     w_shl;
    logic [WIDTH:0]     w_shr;
    logic [WIDTH:0]     w_asr;
    logic [WIDTH-1:0]   w_res;
    logic               w_c;
    logic               w_v;
    logic               w_err;
    logic               w_accept;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_prod_next;

    assign in_ready   = (r_state == S_IDLE) && (!out_valid || out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_mul_done = (r_state == S_MUL) && (r_cnt == '0);

    // INC/DEC reuse the adder/subtractor with a constant second operand
    assign w_addb = (op == OP_INC || op == OP_DEC) ? WIDTH'(1) : b;
    assign w_addc = (op == OP_ADC) ? carry_in : 1'b0;
    assign w_sum  = {1'b0, a} + {1'b0, w_addb} + {{WIDTH{1'b0}}, w_addc};
    assign w_diff = {1'b0, a} - {1'b0, w_addb};

    // One guard bit below/above the operand catches the last bit shifted out
    assign w_sh  = b[SHW-1:0];
    assign w_shl = {1'b0, a} << w_sh;
    assign w_shr = {a, 1'b0} >> w_sh;
    assign w_asr = $unsigned($signed({a, 1'b0}) >>> w_sh);

    assign w_prod_next = r_prod + (r_mplier[0] ? r_mcand : '0);

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        w_err = 1'b0;
        case (op)
            OP_ADD, OP_INC, OP_ADC: begin
                w_res = w_sum[M:0];
                w_c   = w_sum[WIDTH];
                w_v   = (a[M] == w_addb[M]) && (w_sum[M] != a[M]);
            end
            OP_SUB, OP_DEC: begin
                w_res = w_diff[M:0];
                w_c   = w_diff[WIDTH];
                w_v   = (a[M] != w_addb[M]) && (w_diff[M] != a[M]);
            end
            OP_AND: w_res = a & b;
            OP_OR:  w_res = a | b;
            OP_XOR: w_res = a ^ b;
            OP_NOT: w_res = ~a;
            OP_SHL: begin
                w_res = w_shl[M:0];
                w_c   = w_shl[WIDTH];
            end
            OP_SHR: begin
                w_res = w_shr[WIDTH:1];
                w_c   = w_shr[0];
            end
            OP_ASR: begin
                w_res = w_asr[WIDTH:1];
                w_c   = w_asr[0];
            end
            OP_MUL: w_res = '0;
            default: w_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_prod     <= '0;
            r_cnt      <= '0;
            out_valid  <= 1'b0;
            out        <= '0;
            flag_zero  <= 1'b0;
            flag_carry <= 1'b0;
            flag_neg   <= 1'b0;
            flag_ovf   <= 1'b0;
            err        <= 1'b0;
        end else begin
            if (r_state == S_IDLE) begin
                if (w_accept && op == OP_MUL) begin
                    r_state  <= S_MUL;
                    r_mcand  <= {{WIDTH{1'b0}}, a};
                    r_mplier <= b;
                    r_prod   <= '0;
                    r_cnt    <= CW'(WIDTH - 1);
                end
            end else begin
                r_prod   <= w_prod_next;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt - 1'b1;
                if (r_cnt == '0) begin
                    r_state <= S_IDLE;
                end
            end

            if (w_accept && op != OP_MUL) begin
                out_valid  <= 1'b1;
                out        <= w_res;
                flag_zero  <= !w_err && (w_res == '0);
                flag_carry <= w_c;
                flag_neg   <= w_res[M];
                flag_ovf   <= w_v;
                err        <= w_err;
            end else if (w_mul_done) begin
                out_valid  <= 1'b1;
                out        <= w_prod_next[M:0];
                flag_zero  <= (w_prod_next[M:0] == '0);
                flag_carry <= |w_prod_next[2*WIDTH-1:WIDTH];
                flag_neg   <= w_prod_next[M];
                flag_ovf   <= 1'b0;
                err        <= 1'b0;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_pipe.sv
// ============================================================================
// Module   : tb_alu_pipe
// Brief    : Directed self-checking bench for alu_pipe (WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] op = 4'h0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       carry_in = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] y;
    logic       fz, fc, fn, fv, err;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] res;
        logic [4:0] f;      // {Z, C, N, V, err}
    } vec_t;

    alu_pipe #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .carry_in(carry_in),
        .out_valid(out_valid), .out_ready(out_ready), .out(y),
        .flag_zero(fz), .flag_carry(fc), .flag_neg(fn), .flag_ovf(fv), .err(err)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, y, fz, fc, fn, fv, err, in_ready} !== {1'b0, 8'h00, 5'b00000, 1'b1}) begin
            errors++;
            $display("FAIL reset_state: got vld=%b out=%h f=%b%b%b%b%b rdy=%b, want vld=0 out=00 f=00000 rdy=1",
                     out_valid, y, fz, fc, fn, fv, err, in_ready);
        end
        rst = 1'b0;
    endtask

    task automatic test_ops();
        vec_t v[21];
        v[0]  = '{4'h0, 8'hFF, 8'h01, 1'b0, 8'h00, 5'b11000};  // ADD wrap
        v[1]  = '{4'h1, 8'h80, 8'h01, 1'b0, 8'h7F, 5'b00010};  // SUB overflow
        v[2]  = '{4'h1, 8'h01, 8'h02, 1'b0, 8'hFF, 5'b01100};  // SUB borrow
        v[3]  = '{4'h2, 8'h7F, 8'h00, 1'b0, 8'h80, 5'b00110};  // INC
        v[4]  = '{4'h3, 8'h00, 8'h00, 1'b0, 8'hFF, 5'b01100};  // DEC borrow
        v[5]  = '{4'hB, 8'h7F, 8'h00, 1'b1, 8'h80, 5'b00110};  // ADC
        v[6]  = '{4'hB, 8'hFF, 8'hFF, 1'b1, 8'hFF, 5'b01100};  // ADC carry
        v[7]  = '{4'h4, 8'hF0, 8'h3C, 1'b0, 8'h30, 5'b00000};  // AND
        v[8]  = '{4'h5, 8'hF0, 8'h0F, 1'b0, 8'hFF, 5'b00100};  // OR
        v[9]  = '{4'h6, 8'hAA, 8'hAA, 1'b0, 8'h00, 5'b10000};  // XOR
        v[10] = '{4'h7, 8'h0F, 8'h00, 1'b0, 8'hF0, 5'b00100};  // NOT
        v[11] = '{4'h8, 8'h81, 8'h01, 1'b0, 8'h02, 5'b01000};  // SHL
        v[12] = '{4'hA, 8'h80, 8'h03, 1'b0, 8'hF0, 5'b00100};  // ASR
        v[13] = '{4'h9, 8'h81, 8'h08, 1'b0, 8'h81, 5'b00100};  // SHR amount 0
        v[14] = '{4'h9, 8'h81, 8'h01, 1'b0, 8'h40, 5'b01000};  // SHR
        v[15] = '{4'hA, 8'h81, 8'h01, 1'b0, 8'hC0, 5'b01100};  // ASR carry
        v[16] = '{4'hF, 8'h12, 8'h34, 1'b0, 8'h00, 5'b00001};  // illegal F
        v[17] = '{4'hD, 8'h12, 8'h34, 1'b0, 8'h00, 5'b00001};  // illegal D
        v[18] = '{4'h0, 8'h01, 8'h01, 1'b0, 8'h02, 5'b00000};  // err cleared
        v[19] = '{4'h8, 8'h40, 8'h02, 1'b0, 8'h00, 5'b11000};  // SHL out to zero
        v[20] = '{4'h0, 8'h7F, 8'h01, 1'b0, 8'h80, 5'b00110};  // ADD overflow
        out_ready = 1'b1;
        for (int i = 0; i < 21; i++) begin
            op = v[i].op; a = v[i].a; b = v[i].b; carry_in = v[i].cin;
            in_valid = 1'b1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL op%0d_ready: got in_ready=%b, want 1", i, in_ready);
            end
            @(posedge clk);
            #1;
            checks++;
            if ({out_valid, y, fz, fc, fn, fv, err} !== {1'b1, v[i].res, v[i].f}) begin
                errors++;
                $display("FAIL op%0d_result (op=%h a=%h b=%h): got vld=%b out=%h zcnve=%b%b%b%b%b, want vld=1 out=%h zcnve=%b",
                         i, v[i].op, v[i].a, v[i].b, out_valid, y, fz, fc, fn, fv, err, v[i].res, v[i].f);
            end
        end
        in_valid = 1'b0; carry_in = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ops_drain: got out_valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_mul(input logic [7:0] ma, input logic [7:0] mb,
                            input logic [7:0] eres, input logic [4:0] ef);
        out_ready = 1'b1;
        op = 4'hC; a = ma; b = mb; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if ({in_ready, out_valid} !== 2'b00) begin
                errors++;
                $display("FAIL mul_busy cycle %0d: got in_ready=%b out_valid=%b, want 0 0", k, in_ready, out_valid);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if ({out_valid, y, fz, fc, fn, fv, err} !== {1'b1, eres, ef}) begin
            errors++;
            $display("FAIL mul_result %h*%h: got vld=%b out=%h zcnve=%b%b%b%b%b, want vld=1 out=%h zcnve=%b",
                     ma, mb, out_valid, y, fz, fc, fn, fv, err, eres, ef);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        vec_t v[4];
        v[0] = '{4'h1, 8'h05, 8'h01, 1'b0, 8'h04, 5'b00000};
        v[1] = '{4'h6, 8'h0F, 8'hFF, 1'b0, 8'hF0, 5'b00100};
        v[2] = '{4'h2, 8'hFF, 8'h00, 1'b0, 8'h00, 5'b11000};
        v[3] = '{4'h8, 8'h03, 8'h02, 1'b0, 8'h0C, 5'b00000};
        out_ready = 1'b0;
        op = 4'h0; a = 8'h01; b = 8'h02; in_valid = 1'b1;
        @(posedge clk);
        #1;
        op = v[0].op; a = v[0].a; b = v[0].b;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({out_valid, y, fz, fc, fn, fv, err, in_ready} !== {1'b1, 8'h03, 5'b00000, 1'b0}) begin
                errors++;
                $display("FAIL stall cycle %0d: got vld=%b out=%h zcnve=%b%b%b%b%b rdy=%b, want vld=1 out=03 zcnve=00000 rdy=0",
                         k, out_valid, y, fz, fc, fn, fv, err, in_ready);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            op = v[i].op; a = v[i].a; b = v[i].b;
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b%0d_ready: got in_ready=%b, want 1", i, in_ready);
            end
            @(posedge clk);
            #1;
            checks++;
            if ({out_valid, y, fz, fc, fn, fv, err} !== {1'b1, v[i].res, v[i].f}) begin
                errors++;
                $display("FAIL b2b%0d_result: got vld=%b out=%h zcnve=%b%b%b%b%b, want vld=1 out=%h zcnve=%b",
                         i, out_valid, y, fz, fc, fn, fv, err, v[i].res, v[i].f);
            end
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_mul();
        out_ready = 1'b1;
        op = 4'hC; a = 8'h10; b = 8'h11; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({out_valid, in_ready, y, fz, fc, fn, fv, err} !== {1'b0, 1'b1, 8'h00, 5'b00000}) begin
            errors++;
            $display("FAIL reset_mid_mul: got vld=%b rdy=%b out=%h zcnve=%b%b%b%b%b, want vld=0 rdy=1 out=00 zcnve=00000",
                     out_valid, in_ready, y, fz, fc, fn, fv, err);
        end
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mul_discarded: got out_valid=%b, want 0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_ops();
        test_mul(8'h10, 8'h11, 8'h10, 5'b01000);
        test_mul(8'h0F, 8'h0F, 8'hE1, 5'b00100);
        test_back_to_back();
        test_reset_mid_mul();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
